mc_datapath_core: RTL and testbench
===================================

Name: mc_datapath_core

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath core.
- Integrates PC, register file, immediate extender, ALU and an internal control FSM.
- Executes an RV32I subset over one unified instruction/data memory port with a req/ready handshake.
- Adds behaviour the single-cycle core lacks: wait-state tolerance, RV32E register-count option, precise sticky trap, and a retire pulse.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural register count; legal values 16 (RV32E) or 32.
- ALIGN_CHECK, 1, 1 = misaligned load/store address or control-flow target traps; 0 = low address bits are ignored (forced to 00).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid only while mem_req=1.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled in the cycle mem_req & mem_ready.
- mem_ready  in  1  completes the current request this cycle.
- pc  out  32  address of the instruction currently executing.
- instr  out  32  latched current instruction.
- retire  out  1  one-cycle pulse when an instruction completes.
- trap  out  1  sticky fault flag.

Behaviour:
- Reset (synchronous): state=FETCH, pc=RESET_PC, instr=0, all registers=0, retire=0, trap=0. mem_req=0 while reset is high.
- Supported instructions: add, sub, and, or, slt, addi, lw, sw, beq, jal. Anything else traps.
- x0 always reads 0; writes to x0 are dropped.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Holds while !mem_ready. On ready: instr<=mem_rdata, go to DECODE.
  - DECODE: read rs1/rs2 into A/B; build immediate (I/S/B/J). Next state: R/addi -> EXEC; lw/sw -> MEMADR; beq -> BRANCH; jal -> JAL; illegal -> TRAP.
  - EXEC: ALUOut <= A op (B or imm) -> ALUWB.
  - ALUWB: rd <= ALUOut; retire; pc <= pc+4 -> FETCH.
  - MEMADR: ALUOut <= A+imm. Misaligned (ALIGN_CHECK=1) -> TRAP; otherwise lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, addr=ALUOut; hold until ready, latch data -> MEMWB.
  - MEMWB: rd <= data; retire; pc+4 -> FETCH.
  - MEMWR: mem_req=1, mem_we=1, wdata=rs2; hold until ready; retire; pc+4 -> FETCH.
  - BRANCH: if A==B then target=pc+imm, else pc+4. Misaligned target -> TRAP; otherwise pc<=target; retire -> FETCH.
  - JAL: rd <= pc+4; pc <= pc+imm (same alignment check); retire -> FETCH.
  - TRAP: trap=1, mem_req=0, pc frozen at the faulting instruction, no register writes. Exits only on reset.
- Latency with zero-wait memory: beq 3 cycles; add/addi/sw/jal 4; lw 5. Each wait cycle (mem_ready=0) adds 1.
- Handshake: mem_addr, mem_we and mem_wdata are stable while mem_req=1 and mem_ready=0. mem_ready is ignored when mem_req=0.
- A register index >= NUM_REGS in rs1, rs2 or rd traps in DECODE. This applies to indices 16–31 when NUM_REGS=16.
- Arithmetic: 32-bit wrap-around. slt is signed. pc+4 wraps at 2^32 with no trap.
- Reset asserted mid-request drops mem_req in the following cycle; no write is committed after reset is sampled.

Test Plan:
- Reset, then addi x1,x0,5 at RESET_PC=0x100 with zero-wait memory -> x1=5; retire on cycle 4; next fetch address 0x104.
- add x3,x1,x2 with x1=0x7FFF_FFFF, x2=1 -> x3=0x8000_0000. slt x4,x3,x1 -> x4=1.
- sw x3,8(x0) then lw x5,8(x0), with 2 wait states per access -> mem_addr stable while waiting; x5=0x8000_0000; lw retires in 5+2 cycles.
- beq x0,x0,-4 at pc=0x10 -> pc=0x0C after 3 cycles. beq with unequal operands -> pc=0x14.
- jal x1,+8 at 0x20 -> x1=0x24, pc=0x28. Then lw from address 0x2 with ALIGN_CHECK=1 -> trap=1, pc held, mem_req=0 until reset.
- NUM_REGS=16: addi x17,x0,1 -> trap in DECODE, no write. Illegal opcode 0x0000_0000 -> trap.

Source files
------------

// File: rtl/mc_datapath_core.sv
// Multi-cycle RV32I-subset core: PC, register file, immediates, ALU and
// control FSM sharing one instruction/data memory port.
module mc_datapath_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NUM_REGS    = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        retire,
  output logic        trap
);
  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_JALWB, S_TRAP
  } state_t;

  state_t      state, state_n;
  logic [31:0] rf [NUM_REGS];
  logic [31:0] a, b, imm, alu_out, mdr;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_jal;
  logic        use_rs1, use_rs2, use_rd, bad_reg;
  logic [31:0] imm_sel, ra, rb, alu_res, ea, br_tgt, pc4;
  logic        ea_bad, br_bad, jal_bad;
  logic        rf_we;
  logic [31:0] rf_wd;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  assign is_r = (opc == 7'b0110011) &&
    (((f7 == 7'h00) && (f3 inside {3'd0, 3'd2, 3'd6, 3'd7})) ||
     ((f7 == 7'h20) && (f3 == 3'd0)));
  assign is_addi = (opc == 7'b0010011) && (f3 == 3'd0);
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'd2);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'd2);
  assign is_beq  = (opc == 7'b1100011) && (f3 == 3'd0);
  assign is_jal  = (opc == 7'b1101111);

  // Only the register fields an instruction actually uses are range checked
  assign use_rs1 = is_r | is_addi | is_lw | is_sw | is_beq;
  assign use_rs2 = is_r | is_sw | is_beq;
  assign use_rd  = is_r | is_addi | is_lw | is_jal;
  assign bad_reg = (use_rs1 && (int'(rs1) >= NUM_REGS)) ||
                   (use_rs2 && (int'(rs2) >= NUM_REGS)) ||
                   (use_rd  && (int'(rd)  >= NUM_REGS));

  assign ra = (rs1 == 5'd0) ? 32'd0 : rf[rs1[IW-1:0]];
  assign rb = (rs2 == 5'd0) ? 32'd0 : rf[rs2[IW-1:0]];

  always_comb begin
    imm_sel = {{20{instr[31]}}, instr[31:20]};
    unique case (1'b1)
      is_sw:  imm_sel = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      is_beq: imm_sel = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
      is_jal: imm_sel = {{11{instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

  always_comb begin
    alu_res = a + imm;
    if (is_r) begin
      unique case (f3)
        3'd0:    alu_res = f7[5] ? a - b : a + b;
        3'd2:    alu_res = {31'd0, $signed(a) < $signed(b)};
        3'd6:    alu_res = a | b;
        3'd7:    alu_res = a & b;
        default: alu_res = a + b;
      endcase
    end
  end

  assign pc4     = pc + 32'd4;
  assign ea      = a + imm;
  assign br_tgt  = (a == b) ? pc + imm : pc4;
  assign ea_bad  = ALIGN_CHECK && (ea[1:0] != 2'b00);
  assign br_bad  = ALIGN_CHECK && (br_tgt[1:0] != 2'b00);
  assign jal_bad = ALIGN_CHECK && (alu_out[1:0] != 2'b00);

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        if (bad_reg) state_n = S_TRAP;
        else begin
          unique case (1'b1)
            is_r, is_addi: state_n = S_EXEC;
            is_lw, is_sw:  state_n = S_MEMADR;
            is_beq:        state_n = S_BRANCH;
            is_jal:        state_n = S_JAL;
            default:       state_n = S_TRAP;
          endcase
        end
      end
      S_EXEC:   state_n = S_ALUWB;
      S_ALUWB:  state_n = S_FETCH;
      S_MEMADR: state_n = ea_bad ? S_TRAP : (is_lw ? S_MEMRD : S_MEMWR);
      S_MEMRD:  if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:  state_n = S_FETCH;
      S_MEMWR:  if (mem_ready) state_n = S_FETCH;
      S_BRANCH: state_n = br_bad ? S_TRAP : S_FETCH;
      S_JAL:    state_n = S_JALWB;
      S_JALWB:  state_n = jal_bad ? S_TRAP : S_FETCH;
      default:  state_n = S_TRAP;
    endcase
  end

  assign rf_we = (state == S_ALUWB) || (state == S_MEMWB) ||
                 ((state == S_JALWB) && !jal_bad);
  assign rf_wd = (state == S_MEMWB) ? mdr :
                 (state == S_JALWB) ? pc4 : alu_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      if (rf_we && (rd != 5'd0)) rf[rd[IW-1:0]] <= rf_wd;
      unique case (state)
        S_FETCH:  if (mem_ready) instr <= mem_rdata;
        S_DECODE: begin
          a   <= ra;
          b   <= rb;
          imm <= imm_sel;
        end
        S_EXEC:   alu_out <= alu_res;
        S_ALUWB:  pc <= pc4;
        S_MEMADR: alu_out <= ea;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_MEMWB:  pc <= pc4;
        S_MEMWR:  if (mem_ready) pc <= pc4;
        S_BRANCH: if (!br_bad) pc <= {br_tgt[31:2], 2'b00};
        S_JAL:    alu_out <= pc + imm;
        S_JALWB:  if (!jal_bad) pc <= {alu_out[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  // Outputs come from held registers, so they stay put across wait states
  assign mem_req = !reset && ((state == S_FETCH) ||
                   (state == S_MEMRD) || (state == S_MEMWR));
  assign mem_we    = (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : {alu_out[31:2], 2'b00};
  assign mem_wdata = b;
  assign trap      = (state == S_TRAP);
  assign retire    = !reset && ((state == S_ALUWB) || (state == S_MEMWB) ||
                     ((state == S_MEMWR) && mem_ready) ||
                     ((state == S_BRANCH) && !br_bad) ||
                     ((state == S_JALWB) && !jal_bad));
endmodule

// File: tb/tb_mc_datapath_core.sv
// Directed bench: RV32I core at 0x100 with wait states, plus an RV32E
// instance for register-range and illegal-opcode traps.
module tb_mc_datapath_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        reset_a, req_a, we_a, ready_a, retire_a, trap_a;
  logic [31:0] addr_a, wdata_a, rdata_a, pc_a, instr_a;
  logic        reset_b, req_b, we_b, ready_b, retire_b, trap_b;
  logic [31:0] addr_b, wdata_b, rdata_b, pc_b, instr_b;

  mc_datapath_core #(
    .RESET_PC(32'h0000_0100), .NUM_REGS(32), .ALIGN_CHECK(1'b1)
  ) u_a (
    .clk(clk), .reset(reset_a), .mem_req(req_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .mem_ready(ready_a), .pc(pc_a), .instr(instr_a),
    .retire(retire_a), .trap(trap_a)
  );

  mc_datapath_core #(
    .RESET_PC(32'h0000_0000), .NUM_REGS(16), .ALIGN_CHECK(1'b1)
  ) u_b (
    .clk(clk), .reset(reset_b), .mem_req(req_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .mem_ready(ready_b), .pc(pc_b), .instr(instr_b),
    .retire(retire_b), .trap(trap_b)
  );

  logic [31:0] prog_a [256];
  logic [31:0] dmem_a [256];
  bit          wr_v   [256];
  logic [31:0] prog_b [256];
  logic [7:0]  idx_a;
  int          wcnt = 0;
  int          dwait = 0;
  bit          slow_en = 1'b0;

  // Addresses below 0x10 become slow when slow_en is set
  assign idx_a   = addr_a[9:2];
  assign ready_a = !(slow_en && (addr_a < 32'h10)) || (wcnt >= dwait);
  assign rdata_a = wr_v[idx_a] ? dmem_a[idx_a] : prog_a[idx_a];
  assign ready_b = 1'b1;
  assign rdata_b = prog_b[addr_b[9:2]];

  always @(posedge clk) begin
    if (req_a && ready_a) begin
      if (we_a) begin
        dmem_a[idx_a] <= wdata_a;
        wr_v[idx_a]   <= 1'b1;
      end
      wcnt <= 0;
    end else if (req_a) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  bit          sel = 1'b0;
  logic        c_req, c_we, c_ready, c_retire, c_trap;
  logic [31:0] c_addr, c_wdata;
  assign c_req    = sel ? req_b    : req_a;
  assign c_we     = sel ? we_b     : we_a;
  assign c_ready  = sel ? ready_b  : ready_a;
  assign c_retire = sel ? retire_b : retire_a;
  assign c_trap   = sel ? trap_b   : trap_a;
  assign c_addr   = sel ? addr_b   : addr_a;
  assign c_wdata  = sel ? wdata_b  : wdata_a;

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] rs2, rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [31:0] im,
    input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {im[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] im,
    input logic [4:0] rs2, rs1);
    return {im[11:5], rs2, rs1, 3'd2, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] im,
    input logic [4:0] rs2, rs1);
    return {im[12], im[10:5], rs2, rs1, 3'd0, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] im,
    input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one instruction until retire or trap; cyc=-1 on timeout
  task automatic exec(output int cyc, output logic [31:0] faddr,
                      output int unstable);
    logic [31:0] paddr, pwd;
    logic        pwe;
    bit          pend;
    pend = 1'b0;
    paddr = '0;
    pwd = '0;
    pwe = 1'b0;
    cyc = 0;
    unstable = 0;
    faddr = '0;
    repeat (60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) faddr = c_addr;
      if (pend && c_req &&
          ((c_addr !== paddr) || (c_we !== pwe) || (c_wdata !== pwd)))
        unstable++;
      pend  = c_req && !c_ready;
      paddr = c_addr;
      pwe   = c_we;
      pwd   = c_wdata;
      if (c_retire || c_trap) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    cyc = -1;
  endtask

  int          cyc, uns;
  logic [31:0] fa;

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prog_a[i] = '0;
      prog_b[i] = '0;
    end
    prog_a[64]  = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);
    prog_a[65]  = enc_i(32'h200, 5'd0, 3'd2, 5'd1, 7'h03);
    prog_a[66]  = enc_i(32'd1, 5'd0, 3'd0, 5'd2, 7'h13);
    prog_a[67]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    prog_a[68]  = enc_r(7'h00, 5'd1, 5'd3, 3'd2, 5'd4);
    prog_a[69]  = enc_s(32'd8, 5'd3, 5'd0);
    prog_a[70]  = enc_i(32'd8, 5'd0, 3'd2, 5'd5, 7'h03);
    prog_a[71]  = enc_j(-32'sd268, 5'd0);
    prog_a[128] = 32'h7FFF_FFFF;
    prog_a[3]   = enc_i(32'd1, 5'd0, 3'd0, 5'd6, 7'h13);
    prog_a[4]   = enc_b(-32'sd4, 5'd0, 5'd6);
    prog_a[5]   = enc_j(32'd12, 5'd0);
    prog_a[8]   = enc_j(32'd8, 5'd1);
    prog_a[10]  = enc_i(32'd2, 5'd0, 3'd2, 5'd7, 7'h03);
    prog_b[0]   = enc_i(32'd3, 5'd0, 3'd0, 5'd15, 7'h13);
    prog_b[1]   = enc_i(32'd1, 5'd0, 3'd0, 5'd17, 7'h13);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_pc", pc_a, 32'h100);
    chk("rst_instr", instr_a, 32'd0);
    chk("rst_trap", {31'd0, trap_a}, 32'd0);
    chk("rst_retire", {31'd0, retire_a}, 32'd0);
    @(posedge clk);
    #1 reset_a = 1'b0;

    exec(cyc, fa, uns);
    chk("addi_cyc", cyc, 32'd4);
    chk("addi_fetch", fa, 32'h100);
    chk("addi_x1", u_a.rf[1], 32'd5);
    exec(cyc, fa, uns);
    chk("lw_fetch", fa, 32'h104);
    chk("lw_cyc", cyc, 32'd5);
    chk("lw_x1", u_a.rf[1], 32'h7FFF_FFFF);
    exec(cyc, fa, uns);
    chk("addi2_cyc", cyc, 32'd4);
    chk("addi2_x2", u_a.rf[2], 32'd1);
    exec(cyc, fa, uns);
    chk("add_cyc", cyc, 32'd4);
    chk("add_x3", u_a.rf[3], 32'h8000_0000);
    exec(cyc, fa, uns);
    chk("slt_cyc", cyc, 32'd4);
    chk("slt_x4", u_a.rf[4], 32'd1);

    slow_en = 1'b1;
    dwait = 2;
    exec(cyc, fa, uns);
    chk("sw_cyc", cyc, 32'd6);
    chk("sw_stable", uns, 32'd0);
    exec(cyc, fa, uns);
    chk("lw2_cyc", cyc, 32'd7);
    chk("lw2_stable", uns, 32'd0);
    chk("lw2_x5", u_a.rf[5], 32'h8000_0000);
    chk("sw_mem", dmem_a[2], 32'h8000_0000);
    slow_en = 1'b0;

    exec(cyc, fa, uns);
    chk("jal0_cyc", cyc, 32'd4);
    chk("jal0_x0", u_a.rf[0], 32'd0);
    exec(cyc, fa, uns);
    chk("beq_t_fetch", fa, 32'h10);
    chk("beq_t_cyc", cyc, 32'd3);
    exec(cyc, fa, uns);
    chk("beq_t_pc", fa, 32'h0C);
    chk("addi6_cyc", cyc, 32'd4);
    exec(cyc, fa, uns);
    chk("beq_n_cyc", cyc, 32'd3);
    exec(cyc, fa, uns);
    chk("beq_n_pc", fa, 32'h14);
    exec(cyc, fa, uns);
    chk("jal1_fetch", fa, 32'h20);
    chk("jal1_cyc", cyc, 32'd4);
    chk("jal1_x1", u_a.rf[1], 32'h24);

    exec(cyc, fa, uns);
    chk("mis_fetch", fa, 32'h28);
    chk("mis_cyc", cyc, 32'd4);
    chk("mis_trap", {31'd0, trap_a}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("trap_req", {31'd0, req_a}, 32'd0);
      chk("trap_pc", pc_a, 32'h28);
      chk("trap_ret", {31'd0, retire_a}, 32'd0);
    end
    chk("trap_x7", u_a.rf[7], 32'd0);
    @(posedge clk);
    #1 reset_a = 1'b1;
    @(negedge clk);
    chk("rst2_req", {31'd0, req_a}, 32'd0);
    @(negedge clk);
    chk("rst2_trap", {31'd0, trap_a}, 32'd0);
    chk("rst2_pc", pc_a, 32'h100);

    sel = 1'b1;
    @(posedge clk);
    #1 reset_b = 1'b0;
    exec(cyc, fa, uns);
    chk("e_addi_cyc", cyc, 32'd4);
    chk("e_x15", u_b.rf[15], 32'd3);
    exec(cyc, fa, uns);
    chk("e_x17_cyc", cyc, 32'd3);
    chk("e_x17_trap", {31'd0, trap_b}, 32'd1);
    chk("e_x17_pc", pc_b, 32'h4);
    chk("e_x1", u_b.rf[1], 32'd0);
    @(posedge clk);
    #1 reset_b = 1'b1;
    prog_b[0] = 32'h0000_0000;
    @(posedge clk);
    #1 reset_b = 1'b0;
    exec(cyc, fa, uns);
    chk("ill_cyc", cyc, 32'd3);
    chk("ill_trap", {31'd0, trap_b}, 32'd1);
    chk("ill_pc", pc_b, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
